// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle RISC-V controller and its datapath.
// The controller drives the master side, the datapath the slave side.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       zero;
  logic       pcWrite;
  logic       adrSrc;
  logic       memWrite;
  logic       irWrite;
  logic [1:0] resultSrc;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic       regWrite;
  logic       illegalOp;
  logic [3:0] state;

  modport master (
    input  opcode, zero,
    output pcWrite, adrSrc, memWrite, irWrite, resultSrc,
           aluSrcA, aluSrcB, aluOp, regWrite, illegalOp, state
  );

  modport slave (
    output opcode, zero,
    input  pcWrite, adrSrc, memWrite, irWrite, resultSrc,
           aluSrcA, aluSrcB, aluOp, regWrite, illegalOp, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore controller for a multicycle RV32 subset (lw, sw, R-type, addi, jal, beq).
// Datapath controls are registered alongside the state so they come straight
// from flops; the write enables are additionally gated by reset so nothing is
// written to architectural state while reset is held.
module multicycle_control (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master ctrl
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  // branch marks the state where pcWrite follows the ALU zero flag
  typedef struct packed {
    logic       pcWrite;
    logic       branch;
    logic       adrSrc;
    logic       memWrite;
    logic       irWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       regWrite;
  } ctrl_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  state_t state_q, state_d;
  ctrl_t  ctrl_q;

  // Moore output table; unused encodings 11-15 fall to the all-zero default.
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.irWrite   = 1'b1;
        c.aluSrcB   = 2'b10;
        c.resultSrc = 2'b10;
        c.pcWrite   = 1'b1;
      end
      S_DECODE: begin
        c.aluSrcA = 2'b01;
        c.aluSrcB = 2'b01;
      end
      S_MEMADR: begin
        c.aluSrcA = 2'b10;
        c.aluSrcB = 2'b01;
      end
      S_MEMREAD: begin
        c.adrSrc = 1'b1;
      end
      S_MEMWB: begin
        c.resultSrc = 2'b01;
        c.regWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adrSrc   = 1'b1;
        c.memWrite = 1'b1;
      end
      S_EXECUTER: begin
        c.aluSrcA = 2'b10;
        c.aluOp   = 2'b10;
      end
      S_ALUWB: begin
        c.regWrite = 1'b1;
      end
      S_EXECUTEI: begin
        c.aluSrcA = 2'b10;
        c.aluSrcB = 2'b01;
      end
      S_JAL: begin
        c.aluSrcA = 2'b01;
        c.aluSrcB = 2'b10;
        c.pcWrite = 1'b1;
      end
      S_BEQ: begin
        c.aluSrcA = 2'b10;
        c.aluOp   = 2'b01;
        c.branch  = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_ADDI) || (op == OP_JAL) || (op == OP_BEQ);
  endfunction

  // Next-state logic; opcode is only looked at in DECODE and MEMADR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (ctrl.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ADDI:      state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (ctrl.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register with the matching registered Moore outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_for(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_for(state_d);
    end
  end

  assign ctrl.pcWrite   = ~reset & (ctrl_q.pcWrite | (ctrl_q.branch & ctrl.zero));
  assign ctrl.memWrite  = ~reset & ctrl_q.memWrite;
  assign ctrl.regWrite  = ~reset & ctrl_q.regWrite;
  assign ctrl.irWrite   = ~reset & ctrl_q.irWrite;
  assign ctrl.illegalOp = ~reset & (state_q == S_DECODE) & ~op_supported(ctrl.opcode);
  assign ctrl.adrSrc    = ctrl_q.adrSrc;
  assign ctrl.resultSrc = ctrl_q.resultSrc;
  assign ctrl.aluSrcA   = ctrl_q.aluSrcA;
  assign ctrl.aluSrcB   = ctrl_q.aluSrcB;
  assign ctrl.aluOp     = ctrl_q.aluOp;
  assign ctrl.state     = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset: clk and reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 opcode  input  7  instr[6:0] from the instruction register.
REQ-006 zero  input  1  ALU zero flag, valid in the BEQ state.
REQ-007 pcWrite  output  1  PC register enable.
REQ-008 adrSrc  output  1  memory address select: 0=PC, 1=result.
REQ-009 memWrite  output  1  data memory write enable.
REQ-010 irWrite  output  1  instruction register and oldPC enable.
REQ-011 resultSrc  output  2  result select: 00=ALUOut, 01=memData, 10=ALU result direct.
REQ-012 aluSrcA  output  2  SrcA select: 00=PC, 01=oldPC, 10=rs1 register.
REQ-013 aluSrcB  output  2  SrcB select: 00=rs2 register, 01=immediate, 10=constant 4.
REQ-014 aluOp  output  2  to ALU control: 00=add, 01=subtract, 10=decode funct.
REQ-015 regWrite  output  1  register file write enable.
REQ-016 illegalOp  output  1  unsupported opcode flag.
REQ-017 state  output  4  current state, for debug.

Function
REQ-018 The block SHALL be a Moore FSM; state SHALL be a 4-bit register updated on the rising edge of clk.
REQ-019 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10.
REQ-020 Any output not listed for a state SHALL be 0 in that state.
REQ-021 FETCH: irWrite=1, adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10, pcWrite=1. Next state: DECODE.
REQ-022 DECODE: aluSrcA=01, aluSrcB=01, aluOp=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other -> FETCH
REQ-023 illegalOp SHALL be 1 only in DECODE with an unsupported opcode, i.e. a 1-cycle pulse.
REQ-024 MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00. Next state: MEMREAD if opcode=0000011, else MEMWRITE.
REQ-025 MEMREAD: adrSrc=1, resultSrc=00. Next state: MEMWB.
REQ-026 MEMWB: resultSrc=01, regWrite=1. Next state: FETCH.
REQ-027 MEMWRITE: adrSrc=1, resultSrc=00, memWrite=1. Next state: FETCH.
REQ-028 EXECUTER: aluSrcA=10, aluSrcB=00, aluOp=10. Next state: ALUWB.
REQ-029 EXECUTEI: aluSrcA=10, aluSrcB=01, aluOp=00 (addi only). Next state: ALUWB.
REQ-030 ALUWB: resultSrc=00, regWrite=1. Next state: FETCH.
REQ-031 JAL: aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcWrite=1. Next state: ALUWB.
REQ-032 BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, pcWrite=zero. Next state: FETCH.
REQ-033 Instruction latency in cycles, FETCH to FETCH exclusive:
  - lw: 5
  - sw, R-type, addi, jal: 4
  - beq: 3
  - illegal opcode: 2
REQ-034 State values 11-15 SHALL drive all outputs to 0 and go to FETCH on the next edge.
REQ-035 opcode SHALL be sampled only in DECODE and MEMADR; changes in any other state SHALL have no effect.

Reset
REQ-036 When reset is high at a clk edge, state SHALL become FETCH, regardless of the current state (including mid-instruction).
REQ-037 While reset is high, pcWrite, memWrite, regWrite, irWrite and illegalOp SHALL be forced to 0.
REQ-038 No other architectural effect SHALL occur during reset.
REQ-039 In the first cycle after reset deasserts, state SHALL be 0 and the FETCH outputs SHALL be driven.

Verification
REQ-040 Reset high for 2 cycles, then opcode=0000011 -> states 0,1,2,3,4,0; regWrite=1 only in state 4; aluSrcB=01 in state 2.
REQ-041 opcode=0100011 -> states 0,1,2,5,0; memWrite=1 only in state 5, with adrSrc=1.
REQ-042 opcode=0110011 -> aluOp=10 in state 6 then regWrite=1 in state 7; opcode=0010011 -> aluOp=00, aluSrcB=01 in state 8.
REQ-043 opcode=1100011: zero=1 -> pcWrite=1 in state 10; zero=0 -> pcWrite=0; both cases return to state 0 after 3 cycles.
REQ-044 opcode=0000000 -> illegalOp=1 for exactly one cycle in state 1, then state 0; no regWrite or memWrite pulse.
REQ-045 Reset asserted while in state 5 (memWrite=1) -> memWrite=0 in the same cycle; state=0 on the next edge.
